// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared scratch-memory constants, requester ids and the read return tag
package img_proc_pkg;
    localparam int SC_AW = 16;
    localparam int SC_DW = 128;
    localparam int SC_RD_LAT = 2;
    localparam logic [1:0] REQ_WR = 2'd0;
    localparam logic [1:0] REQ_RD0 = 2'd1;
    localparam logic [1:0] REQ_RD1 = 2'd2;
    typedef struct packed {
        logic v;
        logic id;
    } rd_tag_t;
    function automatic logic [1:0] rr_next(input logic [1:0] k);
        return (k == REQ_RD1) ? REQ_WR : k + 2'd1;
    endfunction
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: three-way round-robin pick starting from the requester named by ptr
module rr_arb3
    import img_proc_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] id
);
    logic [1:0] c1, c2;
    always_comb begin
        c1 = rr_next(ptr);
        c2 = rr_next(c1);
        id = req[ptr] ? ptr : req[c1] ? c1 : c2;
        gnt = (|req) ? 3'b001 << id : 3'b000;
    end
endmodule

// File: rtl/sc_mem_arbiter.sv
// sc_mem_arbiter: one writer and two readers sharing a single-port scratch memory,
// registered command, tagged in-order read return
module sc_mem_arbiter
    import img_proc_pkg::*;
#(
    parameter int AW = SC_AW,
    parameter int DW = SC_DW,
    parameter int RD_LAT = SC_RD_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd0_req,
    input  logic [AW-1:0] rd0_addr,
    input  logic          rd1_req,
    input  logic [AW-1:0] rd1_addr,
    output logic          rd0_gnt,
    output logic          rd1_gnt,
    output logic          rd0_rvalid,
    output logic          rd1_rvalid,
    output logic [DW-1:0] rd0_rdata,
    output logic [DW-1:0] rd1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wt_data,
    output logic          mem_wt_en,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy
);
    logic [2:0] req_v, gnt;
    logic [1:0] gnt_id;
    logic [1:0] ptr_q, ptr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wt_data_q, mem_wt_data_d;
    logic mem_wt_en_q, mem_wt_en_d, mem_rd_en_q, mem_rd_en_d;
    logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic busy_q, busy_d, tag_any;
    rd_tag_t tag_q [0:RD_LAT];
    rd_tag_t tag_d [0:RD_LAT];
    rd_tag_t ret;

    assign req_v = (reset || !enable) ? 3'b000 : {rd1_req, rd0_req, wr_req};

    rr_arb3 u_arb (
        .req(req_v),
        .ptr(ptr_q),
        .gnt(gnt),
        .id (gnt_id)
    );

    assign wr_gnt = gnt[REQ_WR];
    assign rd0_gnt = gnt[REQ_RD0];
    assign rd1_gnt = gnt[REQ_RD1];
    assign mem_addr = mem_addr_q;
    assign mem_wt_data = mem_wt_data_q;
    assign mem_wt_en = mem_wt_en_q;
    assign mem_rd_en = mem_rd_en_q;
    assign rd0_rvalid = rvalid0_q;
    assign rd1_rvalid = rvalid1_q;
    assign rd0_rdata = rdata0_q;
    assign rd1_rdata = rdata1_q;
    assign busy = busy_q;

    always_comb begin
        ptr_d = (|gnt) ? rr_next(gnt_id) : ptr_q;
        mem_wt_en_d = gnt[REQ_WR];
        mem_rd_en_d = gnt[REQ_RD0] | gnt[REQ_RD1];
        mem_addr_d = gnt[REQ_WR] ? wr_addr : gnt[REQ_RD0] ? rd0_addr : gnt[REQ_RD1] ? rd1_addr : mem_addr_q;
        mem_wt_data_d = gnt[REQ_WR] ? wr_data : mem_wt_data_q;
        // stage RD_LAT lines up with mem_rd_data for that read
        tag_d[0] = {mem_rd_en_d, gnt[REQ_RD1]};
        for (int i = 1; i <= RD_LAT; i++)
            tag_d[i] = tag_q[i-1];
        ret = tag_q[RD_LAT];
        rvalid0_d = ret.v & ~ret.id;
        rvalid1_d = ret.v & ret.id;
        rdata0_d = rvalid0_d ? mem_rd_data : rdata0_q;
        rdata1_d = rvalid1_d ? mem_rd_data : rdata1_q;
        tag_any = 1'b0;
        for (int i = 0; i <= RD_LAT; i++)
            tag_any = tag_any | tag_q[i].v;
        busy_d = wr_req | rd0_req | rd1_req | tag_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= REQ_WR;
            mem_addr_q <= '0;
            mem_wt_data_q <= '0;
            mem_wt_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            mem_addr_q <= mem_addr_d;
            mem_wt_data_q <= mem_wt_data_d;
            mem_wt_en_q <= mem_wt_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q <= busy_d;
            for (int i = 0; i <= RD_LAT; i++)
                tag_q[i] <= tag_d[i];
        end
    end
endmodule

// File: tb/tb_sc_mem_arbiter.sv
// tb_sc_mem_arbiter: random and directed traffic against a grant-order scoreboard and memory model
module tb_sc_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int RD_LAT = 2;
    localparam int MN = 64;

    logic clk = 1'b0;
    logic reset, enable, wr_req, rd0_req, rd1_req;
    logic [AW-1:0] wr_addr, rd0_addr, rd1_addr, mem_addr;
    logic [DW-1:0] wr_data, mem_wt_data, mem_rd_data, rd0_rdata, rd1_rdata;
    logic wr_gnt, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, mem_wt_en, mem_rd_en, busy;

    always #5 clk = ~clk;

    sc_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd1_req(rd1_req), .rd1_addr(rd1_addr),
        .rd0_gnt(rd0_gnt), .rd1_gnt(rd1_gnt),
        .rd0_rvalid(rd0_rvalid), .rd1_rvalid(rd1_rvalid),
        .rd0_rdata(rd0_rdata), .rd1_rdata(rd1_rdata),
        .mem_addr(mem_addr), .mem_wt_data(mem_wt_data), .mem_wt_en(mem_wt_en),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return {4{32'(i) * 32'h9E3779B9 + 32'h1234}};
    endfunction

    // scratch memory device: write lands at the edge, read data RD_LAT cycles after the command
    logic [DW-1:0] mem_dev [MN];
    logic [DW-1:0] rp [RD_LAT];
    always @(posedge clk) begin
        if (reset)
            for (int i = 0; i < MN; i++) mem_dev[i] <= init_val(i);
        else if (mem_wt_en)
            mem_dev[mem_addr[5:0]] <= mem_wt_data;
        rp[0] <= mem_rd_en ? mem_dev[mem_addr[5:0]] : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
    assign mem_rd_data = rp[RD_LAT-1];

    typedef struct {
        int due;
        bit id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t q[$];
    logic [DW-1:0] mem_m [MN];
    logic [DW-1:0] e_rdata [2];
    logic [DW-1:0] e_wdata, wd;
    logic [AW-1:0] e_addr;
    logic [AW-1:0] raddr [3];
    bit e_wt_en, e_rd_en, addr_chk, prevreq, rst_drv, en_drv, seq_mode, wt_seen;
    bit pend [3];
    int prob [3];
    int seq [3];
    int gcnt [3];
    int ptr_m, cyc, amax, checks, errors, rv_cnt, first_rv, last_rv;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        ptr_m = 0;
        q.delete();
        e_wt_en = 0;
        e_rd_en = 0;
        e_addr = '0;
        e_wdata = '0;
        e_rdata[0] = '0;
        e_rdata[1] = '0;
        prevreq = 0;
        addr_chk = 1;
        for (int i = 0; i < MN; i++) mem_m[i] = init_val(i);
        for (int k = 0; k < 3; k++) pend[k] = 0;
    endtask

    task automatic step();
        bit due_v, due_id, exp_busy;
        logic [2:0] req, eg;
        int k;
        due_v = q.size() > 0 && q[0].due == cyc;
        due_id = due_v ? q[0].id : 1'b0;
        exp_busy = prevreq;
        foreach (q[i]) if (q[i].due - RD_LAT <= cyc && cyc <= q[i].due) exp_busy = 1;
        if (due_v) e_rdata[due_id] = q[0].data;
        check("rd0_rvalid", rd0_rvalid, due_v && !due_id);
        check("rd1_rvalid", rd1_rvalid, due_v && due_id);
        check("rd0_rdata", rd0_rdata, e_rdata[0]);
        check("rd1_rdata", rd1_rdata, e_rdata[1]);
        check("mem_wt_en", mem_wt_en, e_wt_en);
        check("mem_rd_en", mem_rd_en, e_rd_en);
        check("mem_wt_data", mem_wt_data, e_wdata);
        if (e_wt_en || e_rd_en || addr_chk) check("mem_addr", mem_addr, e_addr);
        check("busy", busy, exp_busy);
        if (rd0_rvalid || rd1_rvalid) begin
            rv_cnt++;
            if (first_rv < 0) first_rv = cyc;
            last_rv = cyc;
        end
        if (mem_wt_en) wt_seen = 1;
        if (due_v) void'(q.pop_front());
        for (k = 0; k < 3; k++)
            if (!pend[k] && (!seq_mode || seq[k] < 32) && $urandom_range(99) < prob[k]) begin
                pend[k] = 1;
                raddr[k] = seq_mode ? AW'(seq[k]) : AW'($urandom_range(amax));
                seq[k]++;
                if (k == 0) wd = {$urandom, $urandom, $urandom, $urandom};
            end
        reset = rst_drv;
        enable = en_drv;
        wr_req = pend[0];
        rd0_req = pend[1];
        rd1_req = pend[2];
        wr_addr = raddr[0];
        rd0_addr = raddr[1];
        rd1_addr = raddr[2];
        wr_data = wd;
        #1;
        req = {pend[2], pend[1], pend[0]};
        eg = 3'b000;
        if (!rst_drv && en_drv)
            for (int off = 0; off < 3; off++) begin
                k = (ptr_m + off) % 3;
                if (eg == 3'b000 && req[k]) eg[k] = 1'b1;
            end
        check("gnt", {rd1_gnt, rd0_gnt, wr_gnt}, eg);
        if (rst_drv) model_reset();
        else begin
            prevreq = |req;
            addr_chk = 0;
            e_wt_en = eg[0];
            e_rd_en = eg[1] | eg[2];
            for (k = 0; k < 3; k++)
                if (eg[k]) begin
                    ptr_m = (k + 1) % 3;
                    e_addr = raddr[k];
                    pend[k] = 0;
                    gcnt[k]++;
                    if (k == 0) begin
                        mem_m[raddr[0][5:0]] = wd;
                        e_wdata = wd;
                    end else
                        q.push_back('{cyc + 2 + RD_LAT, k == 2, mem_m[raddr[k][5:0]]});
                end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_prob(input int p0, input int p1, input int p2);
        prob[0] = p0;
        prob[1] = p1;
        prob[2] = p2;
    endtask

    initial begin
        int g;
        checks = 0;
        errors = 0;
        cyc = 0;
        amax = 15;
        seq_mode = 0;
        rst_drv = 0;
        en_drv = 1;
        wd = '0;
        for (int k = 0; k < 3; k++) begin
            raddr[k] = '0;
            seq[k] = 0;
            gcnt[k] = 0;
        end
        set_prob(0, 0, 0);
        model_reset();
        reset = 1;
        enable = 1;
        {wr_req, rd0_req, rd1_req} = 3'b000;
        wr_addr = '0;
        rd0_addr = '0;
        rd1_addr = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // all three at once straight after reset: WR, RD0, RD1
        pend[0] = 1; pend[1] = 1; pend[2] = 1;
        raddr[0] = 1; raddr[1] = 2; raddr[2] = 3;
        wd = {4{32'hC0DE0001}};
        run(10);

        // write then read the same address on the next cycle
        pend[0] = 1; raddr[0] = 5; wd = 128'hA5;
        step();
        pend[1] = 1; raddr[1] = 5;
        run(8);
        check("raw_a5", rd0_rdata, 128'hA5);

        // two streaming readers over addresses 0..31
        seq_mode = 1;
        seq[1] = 0; seq[2] = 0;
        rv_cnt = 0; first_rv = -1; last_rv = -1;
        set_prob(0, 100, 100);
        run(74);
        check("stream_rv", rv_cnt, 64);
        check("stream_span", last_rv - first_rv + 1, 64);
        seq_mode = 0;
        set_prob(0, 0, 0);

        // enable drops after three read grants
        g = gcnt[1] + gcnt[2] + 3;
        rv_cnt = 0;
        set_prob(0, 100, 100);
        for (int i = 0; i < 20 && gcnt[1] + gcnt[2] < g; i++) step();
        check("three_grants", gcnt[1] + gcnt[2], g);
        en_drv = 0;
        set_prob(0, 0, 0);
        pend[1] = 0; pend[2] = 0;
        run(10);
        check("drain_rv", rv_cnt, 3);
        check("drain_busy", busy, 0);
        en_drv = 1;

        // reset with two reads in flight
        g = gcnt[1] + gcnt[2] + 2;
        set_prob(0, 100, 100);
        for (int i = 0; i < 20 && gcnt[1] + gcnt[2] < g; i++) step();
        rst_drv = 1;
        step();
        rst_drv = 0;
        set_prob(0, 0, 0);
        rv_cnt = 0;
        run(8);
        check("rst_rv", rv_cnt, 0);

        // lone rd1 requester for ten cycles
        g = gcnt[2];
        wt_seen = 0;
        set_prob(0, 0, 100);
        run(10);
        set_prob(0, 0, 0);
        run(8);
        check("rd1_grants", gcnt[2] - g, 10);
        check("no_wt", wt_seen, 0);

        // mixed random traffic with enable gaps and occasional reset
        set_prob(40, 40, 40);
        for (int i = 0; i < 3000; i++) begin
            en_drv = $urandom_range(99) < 90;
            rst_drv = $urandom_range(999) < 5;
            step();
        end
        rst_drv = 0;
        en_drv = 1;
        set_prob(0, 0, 0);
        run(12);
        check("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_mem_arbiter.md
SC_MEM_ARBITER -- requirements
Module: sc_mem_arbiter

Interface
REQ-001 The module SHALL have the parameter AW, default 16, meaning scratch-memory address width.
REQ-002 The module SHALL have the parameter DW, default 128, meaning scratch-memory data width.
REQ-003 The module SHALL have the parameter RD_LAT, default 2, meaning memory read latency in cycles from registered command to mem_rd_data valid; legal range 1..4.
REQ-004 Port clk, input, 1 bit: single clock, rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: when low, no new grants are issued; in-flight reads still complete.
REQ-007 Port wr_req, input, 1 bit: write requester (divider) request. Ports wr_addr (input, AW bits) and wr_data (input, DW bits) carry its address and data.
REQ-008 Port wr_gnt, output, 1 bit: write request accepted this cycle.
REQ-009 Ports rd0_req (input, 1 bit) and rd0_addr (input, AW bits), and rd1_req (input, 1 bit) and rd1_addr (input, AW bits): read requesters 0 and 1 (mapping pixel lanes).
REQ-010 Ports rd0_gnt and rd1_gnt, output, 1 bit each: read request accepted this cycle.
REQ-011 Ports rd0_rvalid and rd1_rvalid, output, 1 bit each, and rd0_rdata and rd1_rdata, output, DW bits each: returned read data and its qualifier.
REQ-012 Ports mem_addr (output, AW bits), mem_wt_data (output, DW bits), mem_wt_en (output, 1 bit) and mem_rd_en (output, 1 bit): registered single-port memory command.
REQ-013 Port mem_rd_data, input, DW bits: memory read data.
REQ-014 Port busy, output, 1 bit: high while any request is pending or any read is in flight.

Function
REQ-015 Handshake SHALL be request-hold: a requester keeps req, addr and data stable until its gnt is high in a cycle; the transfer occurs in that cycle.
REQ-016 At most one gnt SHALL be high per cycle; gnt is combinational from req, enable and the pointer, and is forced low while reset or enable is low.
REQ-017 Arbitration SHALL be round-robin over {WR=0, RD0=1, RD1=2}, with 2-bit pointer ptr naming the highest-priority requester; on a grant to k, ptr <= (k+1) mod 3; with no grant, ptr holds.
REQ-018 For a grant in cycle N, mem_addr, mem_wt_en/mem_rd_en and mem_wt_data SHALL be valid in cycle N+1 only; enables deassert in N+1 if there is no grant in N.
REQ-019 mem_wt_data SHALL update only on a write grant and otherwise hold.
REQ-020 A read granted in cycle N SHALL produce rdK_rdata = mem_rd_data sampled in cycle N+1+RD_LAT, with rdK_rvalid high for exactly one cycle, N+2+RD_LAT.
REQ-021 rdK_rdata SHALL hold its value when rdK_rvalid is low.
REQ-022 Return routing SHALL use a tag shift register RD_LAT+1 stages deep (valid bit + requester id) so back-to-back reads return in grant order; throughput is one access per cycle.
REQ-023 A write and a read to the same address SHALL execute in grant order; a read granted after a write returns the new data.
REQ-024 A pending requester SHALL be granted within 3 cycles while enable is high.
REQ-025 When enable falls, the arbiter SHALL issue no new grants, drain tags, and keep returning rvalid for reads already granted.
REQ-026 busy SHALL equal (wr_req | rd0_req | rd1_req | any tag valid), registered.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL set ptr=0, clear all tags, set mem_wt_en=mem_rd_en=0, mem_addr=0, mem_wt_data=0, rd0/rd1_rvalid=0, rd0/rd1_rdata=0 and busy=0.
REQ-028 Reads in flight when reset asserts mid-operation SHALL be discarded, and no rvalid SHALL follow.

Structure
REQ-029 Shared package img_proc_pkg SHALL hold the requester id constants (REQ_WR, REQ_RD0, REQ_RD1), the AW/DW defaults and SC_RD_LAT.
REQ-030 Round-robin selection SHALL live in sub-module rr_arb3 (inputs req[2:0] and ptr; outputs one-hot gnt[2:0] and id); tag pipeline, command registers and return muxing stay in sc_mem_arbiter.

Verification
REQ-031 After reset, all three requests are high together -> grants in order WR, RD0, RD1 on three consecutive cycles; ptr returns to 0.
REQ-032 Write addr 5 = 128'hA5, then rd0 addr 5 on the next cycle -> rd0_rvalid 4 cycles after rd0_gnt (RD_LAT=2) with rdata 128'hA5.
REQ-033 rd0 and rd1 stream addrs 0..31 continuously -> grants alternate, 64 rvalids with no gaps, data matches the memory model, ids never swap.
REQ-034 Drop enable one cycle after three reads are granted -> no further gnt; exactly the three pending rvalids arrive; busy falls after the last one.
REQ-035 Assert reset while two reads are in flight -> no rvalid afterwards; all outputs at reset values next cycle.
REQ-036 Only rd1_req held high for 10 cycles -> rd1_gnt every cycle, mem_rd_en high cycles 2..11, and mem_wt_en never high.
